// File: rtl/demux_pkg.sv
// Shared constants and per-channel buffer state encoding for the 1-to-4 stream demux.
package demux_pkg;
  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    CH_EMPTY = 2'd0,
    CH_ONE   = 2'd1,
    CH_TWO   = 2'd2
  } chan_state_t;
endpackage

// File: rtl/demux_chan_buf.sv
// Two-entry skid buffer for one demux channel; the write-side ready is registered so it
// never depends on rd_ready within a cycle.
module demux_chan_buf
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data
);
  chan_state_t       state, state_nx;
  logic [DATA_W-1:0] head, tail;
  logic              wr_ok, rd_ok;

  assign wr_ok    = wr & wr_ready;
  assign rd_ok    = rd_valid & rd_ready;
  assign rd_valid = (state != CH_EMPTY);
  assign rd_data  = head;

  always_comb begin
    state_nx = state;
    unique case (state)
      CH_EMPTY: if (wr_ok) state_nx = CH_ONE;
      CH_ONE: begin
        if (wr_ok && !rd_ok)      state_nx = CH_TWO;
        else if (!wr_ok && rd_ok) state_nx = CH_EMPTY;
      end
      CH_TWO:   if (rd_ok) state_nx = CH_ONE;
      default:  state_nx = CH_EMPTY;
    endcase
  end

  // head is always the oldest beat; tail only holds the second entry in CH_TWO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CH_EMPTY;
      wr_ready <= 1'b0;
      head     <= '0;
      tail     <= '0;
    end else begin
      state    <= state_nx;
      wr_ready <= (state_nx != CH_TWO);
      unique case (state)
        CH_EMPTY: if (wr_ok) head <= wr_data;
        CH_ONE: begin
          if (wr_ok && rd_ok) head <= wr_data;
          else if (wr_ok)     tail <= wr_data;
        end
        CH_TWO:   if (rd_ok) head <= tail;
        default:  ;
      endcase
    end
  end
endmodule

// File: rtl/one_four_demux.sv
// Registered 1-to-4 valid/ready demux: select decode, in_ready mux and four channel buffers.
// Optional per-channel saturating beat counters are built when DEMUX_CNT_EN is defined.
module one_four_demux
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
`ifdef DEMUX_CNT_EN
  ,parameter int CNT_W = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic [DATA_W-1:0]      in_data,
  output logic [N_CH-1:0]        out_valid,
  input  logic [N_CH-1:0]        out_ready,
  output logic [N_CH*DATA_W-1:0] out_data
`ifdef DEMUX_CNT_EN
  ,output logic [N_CH*CNT_W-1:0] beat_cnt
`endif
);
  logic [N_CH-1:0]             ch_rdy;
  logic [N_CH-1:0]             ch_wr;
  logic [N_CH-1:0][DATA_W-1:0] ch_data;

  // Head-of-line blocking is intentional: only the selected channel's ready matters.
  assign in_ready = ch_rdy[in_sel];
  assign out_data = ch_data;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign ch_wr[k] = in_valid & in_ready & (in_sel == SEL_W'(k));

    demux_chan_buf #(.DATA_W(DATA_W)) u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr       (ch_wr[k]),
      .wr_data  (in_data),
      .wr_ready (ch_rdy[k]),
      .rd_valid (out_valid[k]),
      .rd_ready (out_ready[k]),
      .rd_data  (ch_data[k])
    );
  end

`ifdef DEMUX_CNT_EN
  logic [N_CH-1:0][CNT_W-1:0] cnt;

  assign beat_cnt = cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++)
        if (ch_wr[k] && (cnt[k] != {CNT_W{1'b1}})) cnt[k] <= cnt[k] + 1'b1;
    end
  end
`endif
endmodule
